// File: rtl/key_edge_detect.sv
// key_edge_detect
//
// Input front end for one mechanical key. The raw pin is brought into the CLK
// domain through a three-stage synchroniser. Edge detection is blanked for
// T100US+1 cycles after reset. After that, every synchronised falling edge
// produces a one-cycle H2L_Sig pulse, and every rising edge a one-cycle
// L2H_Sig pulse. No debouncing is done here; the downstream 20 ms stage
// filters contact bounce.
//
// Optional feature, enabled by defining KEY_DET_LONGPRESS_EN:
//   A long-press detector pulses Long_Sig for one cycle once the key has been
//   held low for LONG_MS milliseconds. It does not auto-repeat. Without the
//   macro, Long_Sig is tied to 0 and the port stays for a stable interface.
//
// Parameters:
//   T100US   blanking length minus one, in CLK cycles
//   T1MS     millisecond prescaler terminal count
//   LONG_MS  long-press threshold in ms (1..1023)
//
// Ports:
//   CLK       system clock
//   RST_n     asynchronous active-low reset
//   Pin_In    raw key pin (idle high, pressed = 0), asynchronous
//   H2L_Sig   one-cycle pulse on a synchronised 1->0 transition
//   L2H_Sig   one-cycle pulse on a synchronised 0->1 transition
//   Long_Sig  one-cycle pulse after the key is held low for LONG_MS ms

module key_edge_detect #(
  parameter logic [15:0] T100US  = 16'd4999,
  parameter logic [15:0] T1MS    = 16'd49999,
  parameter logic [9:0]  LONG_MS = 10'd1000
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic Pin_In,
  output logic H2L_Sig,
  output logic L2H_Sig,
  output logic Long_Sig
);

  logic        s0, s1, s2;
  logic [15:0] blank_cnt;
  logic        armed;

  // The synchroniser resets to the idle (released) level. This means a key
  // already held at reset looks like a transition only in s0/s1. That
  // transition falls inside the blanking window.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s0 <= Pin_In;
      s1 <= s0;
      s2 <= s1;
    end
  end

  // The blanking counter stops at T100US. The armed flag latches there until
  // the next reset.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      blank_cnt <= 16'd0;
      armed     <= 1'b0;
    end else if (!armed) begin
      if (blank_cnt == T100US) begin
        armed <= 1'b1;
      end else begin
        blank_cnt <= blank_cnt + 16'd1;
      end
    end
  end

  // The edge pulses are gated by the registered armed flag. As a result, the
  // first edge that can be reported is the one seen on the cycle after arming.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      H2L_Sig <= 1'b0;
      L2H_Sig <= 1'b0;
    end else begin
      H2L_Sig <= armed & s2 & ~s1;
      L2H_Sig <= armed & ~s2 & s1;
    end
  end

`ifdef KEY_DET_LONGPRESS_EN
  logic [15:0] pre_cnt;
  logic [9:0]  ms_cnt;
  logic        done;

  // The prescaler and ms counter run only while the key is low and armed.
  // Releasing the key, or being unarmed, clears the whole detector.
  // Long_Sig fires on the prescaler wrap that brings ms_cnt to LONG_MS. After
  // that, done freezes both counters until the key is released.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      pre_cnt  <= 16'd0;
      ms_cnt   <= 10'd0;
      done     <= 1'b0;
      Long_Sig <= 1'b0;
    end else begin
      Long_Sig <= 1'b0;
      if (!armed || s1) begin
        pre_cnt <= 16'd0;
        ms_cnt  <= 10'd0;
        done    <= 1'b0;
      end else if (!done) begin
        if (pre_cnt == T1MS) begin
          pre_cnt <= 16'd0;
          ms_cnt  <= ms_cnt + 10'd1;
          if ((ms_cnt + 10'd1) == LONG_MS) begin
            Long_Sig <= 1'b1;
            done     <= 1'b1;
          end
        end else begin
          pre_cnt <= pre_cnt + 16'd1;
        end
      end
    end
  end
`else
  assign Long_Sig = 1'b0;
`endif

endmodule

// File: tb/tb_key_edge_detect.sv
// tb_key_edge_detect
//
// Drives key_edge_detect with directed and randomised key activity, using
// short timing constants. A reference model predicts every output on every
// edge. The model keeps the history of sampled pin levels since the last
// reset release. From that history it derives each output:
//   - Edge pulses: a transition in the pin history, seen two samples late,
//     once the blanking interval has elapsed.
//   - Long press: a run of consecutive armed low cycles reaching
//     LONG_MS*(T1MS+1).

module tb_key_edge_detect;

  localparam logic [15:0] T100US   = 16'd9;
  localparam logic [15:0] T1MS     = 16'd9;
  localparam logic [9:0]  LONG_MS  = 10'd3;
  localparam int          ARM_EDGES = int'(T100US) + 1;
  localparam int          LONG_CYC  = int'(LONG_MS) * (int'(T1MS) + 1);

  logic CLK    = 1'b0;
  logic RST_n  = 1'b0;
  logic Pin_In = 1'b1;
  logic H2L_Sig, L2H_Sig, Long_Sig;

  int n_compared   = 0;
  int n_mismatched = 0;
  bit hist[$];
  int low_run = 0;

  key_edge_detect #(
    .T100US (T100US),
    .T1MS   (T1MS),
    .LONG_MS(LONG_MS)
  ) dut (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .Pin_In  (Pin_In),
    .H2L_Sig (H2L_Sig),
    .L2H_Sig (L2H_Sig),
    .Long_Sig(Long_Sig)
  );

  always #5 CLK = ~CLK;

  // Pin level sampled at edge i (1-based) since reset release; idle before that.
  function automatic bit pin_at(input int i);
    if (i >= 1 && i <= hist.size()) return hist[i-1];
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, hist.size());
    end
  endtask

  // Drive one pin level for one clock edge, update the model, then check #1 later.
  task automatic applyStimulus(input logic pin);
    int k;
    bit armed_prev, e_h2l, e_l2h, e_long;
    Pin_In = pin;
    @(posedge CLK);
    hist.push_back(pin);
    k = hist.size();
    armed_prev = (k - 1) >= ARM_EDGES;
    e_h2l = armed_prev && pin_at(k-3) && !pin_at(k-2);
    e_l2h = armed_prev && !pin_at(k-3) && pin_at(k-2);
    if (armed_prev && !pin_at(k-2)) low_run++;
    else low_run = 0;
`ifdef KEY_DET_LONGPRESS_EN
    e_long = (low_run == LONG_CYC);
`else
    e_long = 1'b0;
`endif
    #1;
    checkOutput("H2L", H2L_Sig, e_h2l);
    checkOutput("L2H", L2H_Sig, e_l2h);
    checkOutput("Long", Long_Sig, e_long);
    checkOutput("H2L&L2H", H2L_Sig & L2H_Sig, 1'b0);
  endtask

  // Assert reset between edges, confirm the asynchronous clear, then release.
  task automatic doReset(input int cycles);
    RST_n = 1'b0;
    #1;
    checkOutput("rst_H2L", H2L_Sig, 1'b0);
    checkOutput("rst_L2H", L2H_Sig, 1'b0);
    checkOutput("rst_Long", Long_Sig, 1'b0);
    repeat (cycles) @(posedge CLK);
    #1;
    RST_n = 1'b1;
    hist.delete();
    low_run = 0;
  endtask

  initial begin
    logic lvl;
    int   len;
    int   t;

    #2;
    doReset(3);

    $display("[TB] reset release, key pressed at cycle 4");
    repeat (3)  applyStimulus(1'b1);
    repeat (45) applyStimulus(1'b0);
    repeat (6)  applyStimulus(1'b1);

    $display("[TB] short press and release");
    repeat (12) applyStimulus(1'b0);
    repeat (6)  applyStimulus(1'b1);

    $display("[TB] one-cycle glitch");
    applyStimulus(1'b0);
    repeat (6) applyStimulus(1'b1);

    $display("[TB] 50-cycle hold then release");
    repeat (50) applyStimulus(1'b0);
    repeat (8)  applyStimulus(1'b1);

    $display("[TB] reset mid-hold");
    repeat (20) applyStimulus(1'b0);
    doReset(2);
    repeat (45) applyStimulus(1'b0);
    repeat (6)  applyStimulus(1'b1);

    $display("[TB] randomised presses around the arming boundary");
    for (int r = 0; r < 8; r++) begin
      doReset($urandom_range(1, 3));
      t = $urandom_range(0, 14);
      repeat (t) applyStimulus(1'b1);
      len = $urandom_range(1, 40);
      repeat (len) applyStimulus(1'b0);
      repeat (5) applyStimulus(1'b1);
    end

    $display("[TB] randomised key activity");
    doReset(2);
    lvl = 1'b1;
    for (int s = 0; s < 80; s++) begin
      lvl = ~lvl;
      len = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(1, 45);
      repeat (len) applyStimulus(lvl);
    end
    repeat (5) applyStimulus(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
